// File: rtl/uart_byte_tx.sv
// uart_byte_tx: byte-wide UART transmitter, 8N1, LSB first.
// Accepts one byte when tx_en & tx_start are high and the request is armed.
// Holding tx_start high after a frame does not resend the byte; tx_start
// must be seen low for at least one edge before the next request.
// Optional build macro UART_TX_PARITY_EN adds an even parity bit (8E1).
// CLKS_PER_BIT = CLK_FREQ / BAUD (truncated) must be at least 2.
module uart_byte_tx #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_en,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_serial
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DONE} state_t;
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift_reg;
    logic             r_armed;
    logic             r_tx_serial;
    logic             r_tx_busy;
    logic             r_tx_done;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_baud_nxt;
    logic [2:0]       w_bit_nxt;
    logic [7:0]       w_shift_nxt;
    logic             w_accept;
    logic             w_baud_end;
    logic             w_serial_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    assign w_baud_end = (r_baud_cnt == CNT_LAST);

    // Next-state, counter updates and next output values. Outputs are decoded
    // from the next state and registered so the pin is glitch-free while the
    // timing matches a decode of the current state.
    always_comb begin
        w_state_nxt  = r_state;
        w_baud_nxt   = r_baud_cnt;
        w_bit_nxt    = r_bit_idx;
        w_shift_nxt  = r_shift_reg;
        w_accept     = 1'b0;
        w_serial_nxt = 1'b1;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (tx_en && tx_start && r_armed) begin
                    w_accept    = 1'b1;
                    w_shift_nxt = tx_data;
                    w_baud_nxt  = '0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt = r_baud_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = S_STOP;
                end else begin
                    w_baud_nxt = r_baud_cnt + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_baud_nxt = r_baud_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        case (w_state_nxt)
            S_START: begin
                w_serial_nxt = 1'b0;
                w_busy_nxt   = 1'b1;
            end
            S_DATA: begin
                w_serial_nxt = w_shift_nxt[w_bit_nxt];
                w_busy_nxt   = 1'b1;
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                w_serial_nxt = ^w_shift_nxt;
                w_busy_nxt   = 1'b1;
            end
`endif
            S_STOP: begin
                w_busy_nxt = 1'b1;
            end
            S_DONE: begin
                w_done_nxt = 1'b1;
            end
            default: begin
                w_serial_nxt = 1'b1;
            end
        endcase
    end

    // State, counters, data and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_baud_cnt  <= '0;
            r_bit_idx   <= '0;
            r_shift_reg <= '0;
            r_tx_serial <= 1'b1;
            r_tx_busy   <= 1'b0;
            r_tx_done   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_baud_cnt  <= w_baud_nxt;
            r_bit_idx   <= w_bit_nxt;
            r_shift_reg <= w_shift_nxt;
            r_tx_serial <= w_serial_nxt;
            r_tx_busy   <= w_busy_nxt;
            r_tx_done   <= w_done_nxt;
        end
    end

    // Request re-arm: a held tx_start sends once; it must be seen low to re-arm.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_armed <= 1'b1;
        end else if (!tx_start) begin
            r_armed <= 1'b1;
        end else if (w_accept) begin
            r_armed <= 1'b0;
        end
    end

    assign tx_serial = r_tx_serial;
    assign tx_busy   = r_tx_busy;
    assign tx_done   = r_tx_done;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Scoreboard bench for uart_byte_tx with CPB = 10. Stimulus queues the byte
// and accept edge it expects; a monitor follows each frame on the line.
module tb_uart_byte_tx;

    localparam int unsigned CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS      = 11;
    localparam int          EXP_FRAMES = 4;
`else
    localparam int unsigned NBITS      = 10;
    localparam int          EXP_FRAMES = 3;
`endif
    localparam int unsigned FLEN = NBITS * CPB;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_en    = 1'b0;
    logic       tx_start = 1'b0;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_serial;

    int unsigned cyc = 0;
    int checks = 0;
    int errors = 0;
    int frames_ok = 0;
    int frames_abort = 0;

    typedef struct {
        logic [7:0]  data;
        int unsigned k;
    } exp_t;
    exp_t sb[$];

    uart_byte_tx #(.CLK_FREQ(1000000), .BAUD(100000)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_en    (tx_en),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx_serial(tx_serial)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected line level for bit slot b of a frame carrying d.
    function automatic logic exp_line(input logic [7:0] d, input int unsigned b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (b == 9 && NBITS == 11) return ^d;
        return 1'b1;
    endfunction

    // Monitor: a frame begins at the first sample with tx_busy high.
    initial begin : monitor
        exp_t e;
        int unsigned s;
        int line_err, busy_err, done_err;
        logic aborted;
        logic skip_wait;
        skip_wait = 1'b0;
        forever begin
            if (!skip_wait) @(negedge clk);
            skip_wait = 1'b0;
            if (rst_n && tx_busy) begin
                s = cyc;
                aborted = 1'b0;
                line_err = 0;
                busy_err = 0;
                done_err = 0;
                chk("frame_expected", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) e = sb.pop_front();
                else begin
                    e.data = 8'h00;
                    e.k = s;
                end
                chk("start_cycle", s, e.k);
                for (int i = 0; i < int'(FLEN); i++) begin
                    if (i > 0) @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (tx_serial !== exp_line(e.data, i / CPB)) line_err++;
                    if (tx_busy !== 1'b1) busy_err++;
                    if (tx_done !== 1'b0) done_err++;
                end
                if (aborted) begin
                    frames_abort++;
                end else begin
                    chk("line_bits", line_err, 0);
                    chk("busy_span", busy_err, 0);
                    chk("done_early", done_err, 0);
                    @(negedge clk);
                    chk("done_pulse", 32'(tx_done), 1);
                    chk("done_busy", 32'(tx_busy), 0);
                    chk("done_line", 32'(tx_serial), 1);
                    @(negedge clk);
                    chk("done_single", 32'(tx_done), 0);
                    frames_ok++;
                    skip_wait = 1'b1;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d);
        exp_t e;
        @(posedge clk);
        #1;
        tx_data  = d;
        tx_en    = 1'b1;
        tx_start = 1'b1;
        e.data = d;
        e.k    = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        int seen;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_done) begin
                seen = 1;
                break;
            end
        end
        chk("done_seen", seen, 1);
    endtask

    task automatic watch_idle(input int n, input string name);
        int cnt;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx_busy !== 1'b0 || tx_serial !== 1'b1) cnt++;
        end
        chk(name, cnt, 0);
    endtask

    initial begin : stimulus
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_serial", 32'(tx_serial), 1);
        chk("reset_busy", 32'(tx_busy), 0);
        chk("reset_done", 32'(tx_done), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tx_en = 1'b1;
        watch_idle(50, "idle_no_start");

        send(8'hA5);
        wait_done();
        watch_idle(30, "no_resend_held_start");

        @(posedge clk);
        #1;
        tx_start = 1'b0;
        send(8'h3C);
        for (int i = 0; i < 4; i++) begin
            repeat (15) @(posedge clk);
            #1;
            tx_data = tx_data + 8'h11;
            tx_en   = ~tx_en;
        end
        wait_done();

        @(posedge clk);
        #1;
        tx_start = 1'b0;
        tx_en    = 1'b0;
        @(posedge clk);
        #1;
        tx_start = 1'b1;
        watch_idle(200, "en_low_no_frame");
        @(posedge clk);
        #1;
        tx_start = 1'b0;

        // 0x0F has bit 4 low, so the reset is visible as the line going high.
        send(8'h0F);
        repeat (52) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("pre_reset_line", 32'(tx_serial), 0);
        @(posedge clk);
        @(negedge clk);
        chk("midreset_serial", 32'(tx_serial), 1);
        chk("midreset_busy", 32'(tx_busy), 0);
        chk("midreset_done", 32'(tx_done), 0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        tx_start = 1'b0;

        send(8'hFF);
        wait_done();
        @(posedge clk);
        #1;
        tx_start = 1'b0;

`ifdef UART_TX_PARITY_EN
        send(8'h07);
        wait_done();
        @(posedge clk);
        #1;
        tx_start = 1'b0;
`endif

        repeat (5) @(negedge clk);
        chk("frames_complete", frames_ok, EXP_FRAMES);
        chk("frames_aborted", frames_abort, 1);
        chk("queue_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
